// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared constants, entry type and index-width helper for the ESM issue scheduler
package esm_pkg;

    localparam int INSTR_W = 32;

    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef struct packed {
        logic               valid;
        logic [INSTR_W-1:0] instr;
        logic               w1;
        logic               w2;
    } esm_entry_t;

    function automatic int esm_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/esm_prio_enc.sv
// rtl/esm_prio_enc.sv - lowest-set-bit priority encoder with found flag
module esm_prio_enc
    import esm_pkg::*;
#(
    parameter int N = 16,
    parameter int W = esm_idx_w(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scanning downward lets the lowest set bit win without a break.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/esm_issue_scheduler.sv
// rtl/esm_issue_scheduler.sv - instruction buffer with scoreboard wakeup and in-order-by-slot issue
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter  int Instr_word_size = INSTR_W,
    parameter  int regnum          = 32,
    parameter  int bs              = 16,
    localparam int RW              = esm_idx_w(regnum),
    localparam int IW              = esm_idx_w(bs)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [Instr_word_size-1:0] Instr_in,
    input  logic                       ALUSrc,
    input  logic                       RegWrite,
    output logic [IW-1:0]              buffer_index,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [IW-1:0]              issue_index,
    output logic [Instr_word_size-1:0] issue_instr,
    input  logic                       wb_valid,
    input  logic [RW-1:0]              wb_rd,
    output logic [IW:0]                count,
    output logic                       full,
    output logic                       empty
);

    esm_entry_t        ent_q [bs];
    esm_entry_t        ent_d [bs];
    logic [regnum-1:0] busy_q, busy_d;
    logic              hold_q, hold_d;
    logic [IW-1:0]     hold_idx_q, hold_idx_d;
    logic [IW:0]       count_q, count_d;

    logic [bs-1:0]     free_vec, ready_vec;
    logic [IW-1:0]     alloc_idx, ready_idx;
    logic              alloc_found, ready_found;
    logic [RW-1:0]     d_rd, d_rs1, d_rs2;
    logic              d_w1, d_w2, disp_fire, issue_fire;

    always_comb begin
        for (int i = 0; i < bs; i++) begin
            free_vec[i]  = !ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid & !ent_q[i].w1 & !ent_q[i].w2;
        end
    end

    esm_prio_enc #(.N(bs), .W(IW)) u_alloc_enc (
        .req   (free_vec),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    esm_prio_enc #(.N(bs), .W(IW)) u_issue_enc (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    assign d_rd  = Instr_in[RD_MSB:RD_LSB];
    assign d_rs1 = Instr_in[RS1_MSB:RS1_LSB];
    assign d_rs2 = Instr_in[RS2_MSB:RS2_LSB];

    assign count        = count_q;
    assign full         = (count_q == (IW+1)'(bs));
    assign empty        = (count_q == '0);
    assign disp_ready   = !full & !(RegWrite & (d_rd != '0) & busy_q[d_rd]);
    assign buffer_index = alloc_idx;
    assign issue_valid  = hold_q | ready_found;
    assign issue_index  = hold_q ? hold_idx_q : ready_idx;
    assign issue_instr  = issue_valid ? ent_q[issue_index].instr : '0;
    assign disp_fire    = disp_valid & disp_ready & alloc_found;
    assign issue_fire   = issue_valid & issue_ready;

    // A writeback landing in the dispatch cycle must not leave the new entry waiting forever.
    assign d_w1 = busy_q[d_rs1] & (d_rs1 != '0) & !(wb_valid & (wb_rd == d_rs1));
    assign d_w2 = !ALUSrc & busy_q[d_rs2] & (d_rs2 != '0) & !(wb_valid & (wb_rd == d_rs2));

    always_comb begin
        ent_d      = ent_q;
        busy_d     = busy_q;
        count_d    = count_q;
        hold_d     = issue_valid & !issue_ready;
        hold_idx_d = issue_index;

        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
            for (int i = 0; i < bs; i++) begin
                if (ent_q[i].valid) begin
                    if (ent_q[i].instr[RS1_MSB:RS1_LSB] == wb_rd) ent_d[i].w1 = 1'b0;
                    if (ent_q[i].instr[RS2_MSB:RS2_LSB] == wb_rd) ent_d[i].w2 = 1'b0;
                end
            end
        end

        if (issue_fire) ent_d[issue_index].valid = 1'b0;

        if (disp_fire) begin
            ent_d[alloc_idx].valid = 1'b1;
            ent_d[alloc_idx].instr = Instr_in;
            ent_d[alloc_idx].w1    = d_w1;
            ent_d[alloc_idx].w2    = d_w2;
            if (RegWrite && (d_rd != '0)) busy_d[d_rd] = 1'b1;
        end

        case ({disp_fire, issue_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < bs; i++) ent_q[i] <= '0;
            busy_q     <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
            count_q    <= '0;
        end else begin
            ent_q      <= ent_d;
            busy_q     <= busy_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
            count_q    <= count_d;
        end
    end

endmodule
